// File: rtl/proc_sequencer_if.sv
// Bus between the program sequencer and its environment: program memory
// port, processor Run/DIN/Done handshake, and status outputs.
interface proc_sequencer_if #(
    parameter int ADDR_W = 7
);
    logic              Start;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemRd;
    logic [8:0]        MemData;
    logic [8:0]        DIN;
    logic              Run;
    logic              Done;
    logic              Busy;
    logic              Halted;
    logic              Error;
    logic [15:0]       InstrCount;

    modport master (
        input  Start, MemData, Done,
        output MemAddr, MemRd, DIN, Run, Busy, Halted, Error, InstrCount
    );

    modport slave (
        output Start, MemData, Done,
        input  MemAddr, MemRd, DIN, Run, Busy, Halted, Error, InstrCount
    );
endinterface

// File: rtl/proc_sequencer.sv
// Program sequencer: fetches 9-bit instruction words from program memory and
// feeds them to a processor over Run/DIN, retiring each one on Done.
module proc_sequencer #(
    parameter int ADDR_W   = 7,
    parameter int MAX_EXEC = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    proc_sequencer_if.master bus
);
    localparam int K_W = $clog2(MAX_EXEC + 1);
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, IMMFETCH, ISSUE, EXEC, HALTED, ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [8:0]        instr_q, instr_d;
    logic [8:0]        imm_q, imm_d;
    logic [K_W-1:0]    k_q, k_d;

    logic              instr_is_mvi;
    logic [ADDR_W:0]   pc_step;
    logic [ADDR_W:0]   pc_next;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
            imm_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            k_q     <= k_d;
        end
    end

    // Extra top bit catches the PC advance running off the end of memory.
    assign instr_is_mvi = (instr_q[8:6] == OP_MVI);
    assign pc_step      = instr_is_mvi ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);
    assign pc_next      = {1'b0, pc_q} + pc_step;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        instr_d     = instr_q;
        imm_d       = imm_q;
        k_d         = k_q;
        bus.MemRd   = 1'b0;
        bus.MemAddr = '0;
        bus.DIN     = '0;
        bus.Run     = 1'b0;

        case (state_q)
            IDLE, HALTED, ERROR: begin
                if (bus.Start) begin
                    pc_d    = '0;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                bus.MemRd   = 1'b1;
                bus.MemAddr = pc_q;
                state_d     = DECODE;
            end
            DECODE: begin
                if (bus.MemData[8:6] == OP_HALT) begin
                    state_d = HALTED;
                end else begin
                    instr_d = bus.MemData;
                    if (bus.MemData[8:6] == OP_MVI) begin
                        bus.MemRd   = 1'b1;
                        bus.MemAddr = pc_q + ADDR_W'(1);
                        state_d     = IMMFETCH;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            IMMFETCH: begin
                imm_d   = bus.MemData;
                state_d = ISSUE;
            end
            ISSUE: begin
                bus.Run = 1'b1;
                bus.DIN = instr_q;
                k_d     = K_W'(1);
                state_d = EXEC;
            end
            EXEC: begin
                bus.DIN = instr_is_mvi ? imm_q : instr_q;
                if (bus.Done) begin
                    cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    if (pc_next[ADDR_W]) begin
                        pc_d    = '0;
                        state_d = HALTED;
                    end else begin
                        pc_d    = pc_next[ADDR_W-1:0];
                        state_d = FETCH;
                    end
                end else if (k_q == K_W'(MAX_EXEC)) begin
                    state_d = ERROR;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Busy       = !(state_q inside {IDLE, HALTED, ERROR});
    assign bus.Halted     = (state_q == HALTED);
    assign bus.Error      = (state_q == ERROR);
    assign bus.InstrCount = cnt_q;
endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: acts as program memory and processor, and checks
// the issued instruction stream and final status against a program-level model.
module tb_proc_sequencer;
    localparam int MAX_EXEC = 3;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    logic start;
    logic done;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    proc_sequencer_if #(.ADDR_W(7)) bus_a ();
    proc_sequencer_if #(.ADDR_W(2)) bus_b ();

    proc_sequencer #(.ADDR_W(7), .MAX_EXEC(MAX_EXEC)) dut_a (
        .Clock(clk), .Reset(rst), .bus(bus_a.master));
    proc_sequencer #(.ADDR_W(2), .MAX_EXEC(MAX_EXEC)) dut_b (
        .Clock(clk), .Reset(rst), .bus(bus_b.master));

    logic [8:0] prog [128];

    always @(posedge clk) if (bus_a.MemRd) bus_a.MemData <= prog[bus_a.MemAddr];
    always @(posedge clk) if (bus_b.MemRd) bus_b.MemData <= prog[{5'b0, bus_b.MemAddr}];

    assign bus_a.Start = start & ~sel;
    assign bus_b.Start = start & sel;
    assign bus_a.Done  = done & ~sel;
    assign bus_b.Done  = done & sel;

    wire        run_o    = sel ? bus_b.Run        : bus_a.Run;
    wire [8:0]  din_o    = sel ? bus_b.DIN        : bus_a.DIN;
    wire        memrd_o  = sel ? bus_b.MemRd      : bus_a.MemRd;
    wire        busy_o   = sel ? bus_b.Busy       : bus_a.Busy;
    wire        halted_o = sel ? bus_b.Halted     : bus_a.Halted;
    wire        error_o  = sel ? bus_b.Error      : bus_a.Error;
    wire [15:0] cnt_o    = sel ? bus_b.InstrCount : bus_a.InstrCount;
    wire [6:0]  pc_o     = sel ? {5'b0, dut_b.pc_q} : dut_a.pc_q;

    // Model inputs: Done latency (EXEC cycle index) for each successive instruction.
    int         lat [$];
    logic [8:0] exp_instr [$];
    logic [8:0] exp_din2 [$];
    int         exp_cnt, exp_pc;
    bit         exp_halt, exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 128; i++) prog[i] = 9'b111_000_000;
    endtask

    task automatic set_lat(input int fixed);
        lat.delete();
        for (int i = 0; i < 130; i++)
            lat.push_back(fixed > 0 ? fixed :
                          (($urandom_range(0, 7) == 0) ? MAX_EXEC + 1 : $urandom_range(1, MAX_EXEC)));
    endtask

    // Walks the program as the processor would see it.
    task automatic model(input int depth);
        int pc = 0;
        int n  = 0;
        exp_instr.delete();
        exp_din2.delete();
        exp_halt = 0;
        exp_err  = 0;
        forever begin
            if (prog[pc][8:6] == 3'b111) begin exp_halt = 1; break; end
            exp_instr.push_back(prog[pc]);
            exp_din2.push_back(prog[pc][8:6] == 3'b001 ? prog[(pc + 1) % depth] : prog[pc]);
            if (lat[n] > MAX_EXEC) begin exp_err = 1; break; end
            n++;
            pc += (prog[pc][8:6] == 3'b001) ? 2 : 1;
            if (pc >= depth) begin pc = 0; exp_halt = 1; break; end
        end
        exp_cnt = n;
        exp_pc  = pc;
    endtask

    task automatic run_prog(input string tag, input int depth, input bit poke);
        int idx = 0;
        int k = 0;
        int cyc = 0;
        bit in_exec = 0;
        bit chk_din2 = 0;
        bit prev_run = 0;
        model(depth);
        @(negedge clk); start = 1; done = 0;
        @(negedge clk); start = 0;
        forever begin
            if (halted_o || error_o) break;
            if (cyc > 2000) begin chk({tag, "_timeout"}, 1, 0); break; end
            cyc++;
            start = 0;
            done  = in_exec ? 1'b0 : 1'($urandom_range(0, 1));
            if (chk_din2) begin
                chk({tag, "_exec_din"}, din_o, exp_din2[idx-1]);
                chk_din2 = 0;
            end
            if (in_exec) begin
                k++;
                chk({tag, "_exec_run_memrd"}, {run_o, memrd_o}, 0);
                if (k == lat[idx-1]) begin done = 1; in_exec = 0; end
                else if (k == MAX_EXEC) in_exec = 0;
                if (poke && k == 1) start = 1;
            end
            if (run_o) begin
                chk({tag, "_run_single"}, prev_run, 0);
                chk({tag, "_issue_din"}, din_o, (idx < exp_instr.size()) ? exp_instr[idx] : 9'h1FF);
                idx++;
                in_exec  = 1;
                k        = 0;
                chk_din2 = 1;
            end
            prev_run = run_o;
            @(negedge clk);
        end
        done = 0;
        start = 0;
        chk({tag, "_issued"}, idx, exp_instr.size());
        chk({tag, "_count"}, cnt_o, exp_cnt);
        chk({tag, "_halted"}, halted_o, exp_halt);
        chk({tag, "_error"}, error_o, exp_err);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_pc"}, pc_o, exp_pc);
    endtask

    initial begin
        int w;
        int len;
        rst = 1; sel = 0; start = 0; done = 0;
        fill_halt();
        repeat (2) @(negedge clk);
        chk("rst_a_outs", {bus_a.Busy, bus_a.Run, bus_a.MemRd, bus_a.Halted, bus_a.Error,
                           bus_a.DIN, bus_a.MemAddr, bus_a.InstrCount}, 0);
        chk("rst_b_outs", {bus_b.Busy, bus_b.Run, bus_b.MemRd, bus_b.Halted, bus_b.Error,
                           bus_b.DIN, bus_b.MemAddr, bus_b.InstrCount}, 0);
        rst = 0;

        // mv R1,R2 then HALT
        fill_halt(); prog[0] = 9'b000_001_010; set_lat(1);
        run_prog("mv", 128, 0);

        // mvi R3,#0A5 then HALT
        fill_halt(); prog[0] = 9'b001_011_000; prog[1] = 9'h0A5; set_lat(1);
        run_prog("mvi", 128, 0);

        // add with Done on the last allowed EXEC cycle
        fill_halt(); prog[0] = 9'b010_000_001; set_lat(MAX_EXEC);
        run_prog("add_slow", 128, 1);

        // timeout, then restart from address 0
        set_lat(MAX_EXEC + 1);
        run_prog("timeout", 128, 0);
        fill_halt(); prog[0] = 9'b000_001_010; set_lat(2);
        run_prog("restart", 128, 0);

        // address wrap on the 2-bit instance
        sel = 1;
        for (int i = 0; i < 4; i++) prog[i] = 9'b000_001_010 + 9'(i);
        set_lat(1);
        run_prog("wrap_mv", 4, 0);
        prog[3] = 9'b001_010_000;
        set_lat(0);
        run_prog("wrap_mvi", 4, 1);
        sel = 0;

        // reset while in EXEC, with Done asserted on the same edge
        fill_halt(); prog[0] = 9'b000_001_010;
        @(negedge clk); start = 1; done = 0;
        @(negedge clk); start = 0;
        w = 0;
        while (!run_o && w < 20) begin @(negedge clk); w++; end
        chk("rst_exec_reach_issue", run_o, 1);
        @(negedge clk);
        rst = 1; done = 1;
        @(negedge clk);
        rst = 0; done = 0;
        chk("rst_exec_outs", {run_o, busy_o, memrd_o, halted_o, error_o, din_o, cnt_o}, 0);
        chk("rst_exec_pc", pc_o, 0);

        // random programs
        for (int t = 0; t < 16; t++) begin
            fill_halt();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++)
                prog[i] = {3'($urandom_range(0, 6)), 6'($urandom)};
            set_lat(0);
            run_prog("rand_a", 128, 1'($urandom_range(0, 1)));
        end
        sel = 1;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 4; i++)
                prog[i] = {3'($urandom_range(0, 6)), 6'($urandom)};
            set_lat(0);
            run_prog("rand_b", 4, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/proc_sequencer.md
PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 7, sets program-memory address width.
REQ-002 Parameter MAX_EXEC, default 3, is the maximum EXEC cycles allowed before Done is required.
REQ-003 Clock  in  1  is the single clock; all state updates occur on its rising edge.
REQ-004 Reset  in  1  is a synchronous, active-high reset.
REQ-005 Start  in  1  is a pulse that begins program execution from address 0.
REQ-006 MemAddr  out  ADDR_W  is the program-memory read address.
REQ-007 MemRd  out  1  is the read strobe; MemData is valid exactly one cycle after MemRd=1.
REQ-008 MemData  in  9  is the program word, with opcode in bits [8:6], X in [5:3] and Y in [2:0].
REQ-009 DIN  out  9  drives the processor DIN bus.
REQ-010 Run  out  1  drives the processor Run input.
REQ-011 Done  in  1  is the processor Done output.
REQ-012 Busy  out  1  is 1 in every state except IDLE, HALTED and ERROR.
REQ-013 Halted  out  1  is 1 in state HALTED.
REQ-014 Error  out  1  is 1 in state ERROR.
REQ-015 InstrCount  out  16  holds the number of retired instructions.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, DECODE, IMMFETCH, ISSUE, EXEC, HALTED and ERROR.
REQ-017 In IDLE, Start=1 SHALL load PC to 0 and InstrCount to 0, and the next state SHALL be FETCH.
REQ-018 In FETCH: MemRd=1, MemAddr=PC; the next state SHALL be DECODE.
REQ-019 In DECODE, MemData SHALL be latched into INSTR, with the following branches:
- opcode 3'b111 (HALT): next state HALTED, with PC, InstrCount and INSTR unchanged.
- opcode 3'b001 (mvi): MemRd=1, MemAddr=PC+1 (mod 2^ADDR_W), next state IMMFETCH.
- otherwise: next state ISSUE.
REQ-020 In IMMFETCH, MemData SHALL be latched into IMM, and the next state SHALL be ISSUE.
REQ-021 In ISSUE: Run=1 and DIN=INSTR for exactly one cycle; the next state SHALL be EXEC with the EXEC cycle counter k=1.
REQ-022 In EXEC: Run=0; DIN=IMM when INSTR is mvi, otherwise DIN=INSTR.
REQ-023 In EXEC, Done=1 SHALL retire the instruction on that edge:
- PC advances by 2 for mvi and by 1 otherwise.
- InstrCount increments, saturating at 16'hFFFF.
- Next state is FETCH.
REQ-024 When the PC advance carries past 2^ADDR_W-1, the instruction SHALL still retire, and the next state SHALL be HALTED instead of FETCH, with PC=0.
REQ-025 In EXEC with Done=0, k SHALL increment; when k=MAX_EXEC and Done=0, the next state SHALL be ERROR.
REQ-026 Done=1 in any state other than EXEC SHALL be ignored.
REQ-027 Start SHALL be ignored while Busy=1.
REQ-028 Start=1 in HALTED or ERROR SHALL restart exactly as from IDLE.
REQ-029 MemRd SHALL be 0 in every state other than FETCH and DECODE (mvi branch).
REQ-030 DIN SHALL be 9'b0 in IDLE, HALTED and ERROR.
REQ-031 All outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from Done to Run or MemRd.

Reset
REQ-032 Reset=1 at a rising edge SHALL set state=IDLE, PC=0, InstrCount=0, INSTR=0, IMM=0, k=0, with all outputs 0 from the next cycle.
REQ-033 Reset SHALL take priority over Start, Done and any in-flight instruction, and no retirement SHALL occur on a reset edge.

Verification
REQ-034 mv program: Start, mem[0]=9'b000_001_010 (mv R1,R2), mem[1]=HALT, Done=1 in the first EXEC cycle -> Run high for 1 cycle, InstrCount=1, Halted=1 with PC=1.
REQ-035 mvi program: mem[0]=9'b001_011_000, mem[1]=9'h0A5, mem[2]=HALT -> DIN=9'b001011000 with Run=1, next cycle DIN=9'h0A5, InstrCount=1, PC=2 on halt.
REQ-036 add program: mem[0]=9'b010_000_001, Done asserted in EXEC k=3 -> retires, with no Error.
REQ-037 Timeout: Done held 0 after ISSUE -> Error=1 after 3 EXEC cycles, Busy=0; then Start -> restart at address 0.
REQ-038 Wrap and reset: ADDR_W=2, with mem[0..3] all mv -> Halted after 4 retirements, PC=0; a separate run with Reset=1 asserted in EXEC -> IDLE, Run=0, InstrCount=0 on the next cycle.
